dat_transfer_sequencer: RTL and testbench
=========================================

Name: dat_transfer_sequencer

Overview:
Host-clock-domain sequencer that runs a multi-block DAT transfer through the DAT physical layer.
- Accepts one transfer request: direction, block count, single/multiple.
- Issues one strobe/ack handshake per block to the phys layer and counts completed blocks.
- On writes, checks the card's 3-bit data-response token and retries CRC-rejected blocks.
- Reports completion or error to the host register side. Sits between the host register/FIFO logic and the DAT phys block.

Parameters:
BLK_W, 4, width of block count and block counter
MAX_RETRY, 2, retries allowed per block after a CRC-error token
RETRY_W, 2, width of retry counter; must hold MAX_RETRY

Ports:
clock  in  1  host clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  transfer request; sampled only in IDLE
req_ready  out  1  high in IDLE only
req_write  in  1  1=write to card, 0=read
req_blocks  in  BLK_W  number of blocks; 0 treated as 1
req_multiple  in  1  multiple-block transfer flag, forwarded
fifo_okay  in  1  FIFO has data (write) or space (read) for one block
phys_strobe  out  1  start-block request to phys
phys_ack  out  1  acknowledge of phys completion
phys_write  out  1  latched direction to phys
phys_multiple  out  1  latched multiple flag to phys
phys_complete  in  1  phys finished current block
phys_token  in  3  data-response token; valid while phys_complete=1
phys_timeout  in  1  phys timeout; valid while phys_complete=1
blocks_done  out  BLK_W  blocks completed successfully
busy  out  1  high in every state except IDLE
transfer_complete  out  1  one-cycle pulse on successful end
error  out  1  sticky until next accepted request
error_code  out  2  0 none, 1 CRC retries exhausted, 2 write error/bad token, 3 timeout

Behaviour:
- Reset (async, active-low):
  - state=IDLE.
  - All outputs 0 except req_ready=1.
  - Counters and latched request cleared.
  - Reset mid-transfer abandons the transfer immediately; no pulse, no error.
- IDLE:
  - On req_valid=1, latch write/multiple/blocks (0 becomes 1); clear blocks_done, retry count, error, error_code.
  - Next state WAIT_FIFO. req_ready drops the following cycle.
- WAIT_FIFO: wait for fifo_okay=1, then go to STROBE.
- STROBE:
  - phys_strobe=1, held until phys_complete=1 is sampled.
  - On that cycle: drop strobe, capture token/timeout, go to CHECK.
- CHECK (one cycle, evaluation priority):
  1. timeout=1 -> ERROR, code 3.
  2. Read: token ignored -> ACK, mark success.
  3. Write, token 3'b010 -> ACK, success.
  4. Write, token 3'b101 -> if retry<MAX_RETRY then retry+1, ACK, mark retry; else ERROR code 1.
  5. Write, any other token (incl. 3'b110) -> ERROR code 2.
- ACK:
  - phys_ack=1 until phys_complete=0 is sampled; then drop ack.
  - On success: blocks_done+1, retry cleared.
  - If blocks_done (after increment) equals latched count -> DONE; else WAIT_FIFO.
  - On retry: blocks_done unchanged -> WAIT_FIFO, same block resent.
- DONE: transfer_complete=1 for exactly one cycle -> IDLE.
- ERROR:
  - Set error=1 and error_code.
  - phys_ack=1 until phys_complete=0 -> IDLE.
  - error stays high in IDLE until the next request is accepted.
- Latency:
  - Request accepted to first strobe: 2 cycles with fifo_okay=1.
  - Last ack low to transfer_complete: 1 cycle.
- blocks_done never wraps: max value is 2^BLK_W-1, and count cannot exceed it.
- phys_complete high already on STROBE entry is accepted on the first STROBE cycle.

Optional Feature:
Macro SEQ_ABORT_EN.
- Defined:
  - Adds input `abort` (1 bit).
  - abort=1 in any state except IDLE/DONE/ERROR drops phys_strobe and forces ERROR with error_code=2 on the next edge.
  - If the phys handshake is open, ERROR holds phys_ack until phys_complete=0.
  - abort in IDLE is ignored.
- Undefined: no port; transfers run to completion or error only.

Test Plan:
- Write, req_blocks=2, fifo_okay=1, phys returns token 3'b010 twice -> two strobe/ack handshakes, blocks_done=2, one transfer_complete pulse, error=0.
- Write, 1 block, tokens 3'b101, 3'b101, 3'b010 with MAX_RETRY=2 -> three strobes, blocks_done=1, transfer_complete pulse, error=0.
- Write, 1 block, token 3'b101 three times -> error=1, error_code=1, no transfer_complete, busy=0 after ack drops.
- Read, req_blocks=3, token 3'b000, fifo_okay low 10 cycles before block 2 -> strobe delayed 10 cycles, blocks_done=3, complete pulse.
- Write, 1 block, phys_timeout=1 with complete -> error_code=3. Then reset asserted low mid-STROBE on a new request -> all outputs 0, req_ready=1 immediately.
- Write, req_blocks=0 -> exactly one block transferred, blocks_done=1.

Source files
------------

// File: rtl/dat_seq_if.sv
// Host/phys-side bundle for dat_transfer_sequencer. Optional abort port
// exists only when SEQ_ABORT_EN is defined.
interface dat_seq_if #(parameter int BLK_W = 4);
  logic             req_valid, req_ready, req_write, req_multiple;
  logic [BLK_W-1:0] req_blocks;
  logic             fifo_okay;
  logic             phys_strobe, phys_ack, phys_write, phys_multiple;
  logic             phys_complete, phys_timeout;
  logic [2:0]       phys_token;
  logic [BLK_W-1:0] blocks_done;
  logic             busy, transfer_complete, error;
  logic [1:0]       error_code;
`ifdef SEQ_ABORT_EN
  logic             abort;
`endif

  // master = the sequencer itself
  modport master (
    input  req_valid, req_write, req_blocks, req_multiple, fifo_okay,
           phys_complete, phys_token, phys_timeout,
`ifdef SEQ_ABORT_EN
           abort,
`endif
    output req_ready, phys_strobe, phys_ack, phys_write, phys_multiple,
           blocks_done, busy, transfer_complete, error, error_code
  );

  modport slave (
    output req_valid, req_write, req_blocks, req_multiple, fifo_okay,
           phys_complete, phys_token, phys_timeout,
`ifdef SEQ_ABORT_EN
           abort,
`endif
    input  req_ready, phys_strobe, phys_ack, phys_write, phys_multiple,
           blocks_done, busy, transfer_complete, error, error_code
  );
endinterface

// File: rtl/dat_transfer_sequencer.sv
// Multi-block DAT transfer sequencer: one strobe/ack handshake per block,
// write-token checking with CRC retry. Define SEQ_ABORT_EN to add an abort input.
module dat_transfer_sequencer #(
  parameter int BLK_W     = 4,
  parameter int MAX_RETRY = 2,
  parameter int RETRY_W   = 2
) (
  input  logic      clock,
  input  logic      reset,
  dat_seq_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FIFO, S_STROBE, S_CHECK, S_ACK, S_DONE, S_ERROR
  } state_t;

  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

  state_t             state, state_nxt;
  logic               wr_q, mult_q, to_q, succ_q, err_q;
  logic [BLK_W-1:0]   cnt_q, done_q, done_inc;
  logic [RETRY_W-1:0] retry_q;
  logic [2:0]         tok_q;
  logic [1:0]         code_q, chk_code;
  logic               chk_succ, chk_retry, abort_hit, strobe, ack;

`ifdef SEQ_ABORT_EN
  assign abort_hit = bus.abort && (state inside {S_WAIT_FIFO, S_STROBE, S_CHECK, S_ACK});
`else
  assign abort_hit = 1'b0;
`endif

  // Block outcome from the token/timeout captured at the end of STROBE
  always_comb begin
    chk_code  = 2'd0;
    chk_succ  = 1'b0;
    chk_retry = 1'b0;
    if (to_q)                          chk_code = 2'd3;
    else if (!wr_q || tok_q == 3'b010) chk_succ = 1'b1;
    else if (tok_q == 3'b101) begin
      if (retry_q < MAX_R) chk_retry = 1'b1;
      else                 chk_code  = 2'd1;
    end else                           chk_code = 2'd2;
  end

  assign done_inc = (done_q == '1) ? done_q : done_q + 1'b1;

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    strobe    = 1'b0;
    ack       = 1'b0;
    case (state)
      S_IDLE:      if (bus.req_valid) state_nxt = S_WAIT_FIFO;
      S_WAIT_FIFO: if (bus.fifo_okay) state_nxt = S_STROBE;
      S_STROBE: begin
        strobe = 1'b1;
        if (bus.phys_complete) state_nxt = S_CHECK;
      end
      S_CHECK:     state_nxt = (chk_succ || chk_retry) ? S_ACK : S_ERROR;
      S_ACK: begin
        ack = 1'b1;
        if (!bus.phys_complete)
          state_nxt = (succ_q && done_inc == cnt_q) ? S_DONE : S_WAIT_FIFO;
      end
      S_DONE:      state_nxt = S_IDLE;
      S_ERROR: begin
        ack = 1'b1;
        if (!bus.phys_complete) state_nxt = S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = S_ERROR;
      strobe    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      mult_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= '0;
      retry_q <= '0;
      tok_q   <= '0;
      to_q    <= 1'b0;
      succ_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else if (abort_hit) begin
      err_q  <= 1'b1;
      code_q <= 2'd2;
    end else begin
      case (state)
        S_IDLE: if (bus.req_valid) begin
          wr_q    <= bus.req_write;
          mult_q  <= bus.req_multiple;
          cnt_q   <= (bus.req_blocks == '0) ? BLK_W'(1) : bus.req_blocks;
          done_q  <= '0;
          retry_q <= '0;
          err_q   <= 1'b0;
          code_q  <= 2'd0;
        end
        S_STROBE: if (bus.phys_complete) begin
          tok_q <= bus.phys_token;
          to_q  <= bus.phys_timeout;
        end
        S_CHECK: begin
          succ_q <= chk_succ;
          if (chk_retry) retry_q <= retry_q + 1'b1;
          if (!chk_succ && !chk_retry) begin
            err_q  <= 1'b1;
            code_q <= chk_code;
          end
        end
        // a retried block leaves blocks_done alone so the same block is resent
        S_ACK: if (!bus.phys_complete && succ_q) begin
          done_q  <= done_inc;
          retry_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready         = (state == S_IDLE);
  assign bus.busy              = (state != S_IDLE);
  assign bus.transfer_complete = (state == S_DONE);
  assign bus.phys_strobe       = strobe;
  assign bus.phys_ack          = ack;
  assign bus.phys_write        = wr_q;
  assign bus.phys_multiple     = mult_q;
  assign bus.blocks_done       = done_q;
  assign bus.error             = err_q;
  assign bus.error_code        = code_q;
endmodule

// File: tb/tb_dat_transfer_sequencer.sv
// Bench for dat_transfer_sequencer: directed vector table, fifo-stall and
// reset-mid-transfer sequences, then random transfers against a block-level model.
module tb_dat_transfer_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dat_seq_if #(.BLK_W(4)) bus ();
  dat_transfer_sequencer #(.BLK_W(4), .MAX_RETRY(2), .RETRY_W(2)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [3:0] tq[$];   // {timeout, token} handed out per strobe

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Transfer outcome straight from the block/retry rules
  task automatic model(input bit wr, input int blocks, input logic [3:0] toks[$],
                       output int done, output int err, output int code,
                       output int stb, output int cpl);
    int n, retry, idx;
    logic [3:0] t;
    n = (blocks == 0) ? 1 : blocks;
    done = 0; err = 0; code = 0; stb = 0; cpl = 0; retry = 0; idx = 0;
    while (done < n) begin
      t = (idx < toks.size()) ? toks[idx] : 4'h2;
      idx++; stb++;
      if (t[3]) begin err = 1; code = 3; return; end
      if (!wr || t[2:0] == 3'b010) begin done++; retry = 0; end
      else if (t[2:0] == 3'b101) begin
        if (retry < 2) retry++;
        else begin err = 1; code = 1; return; end
      end else begin err = 1; code = 2; return; end
    end
    cpl = 1;
  endtask

  // Request + phys responder; returns strobe/pulse counts and timing marks
  task automatic do_xfer(input bit wr, input int blocks, input bit hold,
                         output int stb, output int cpl, output int fs, output int gap);
    int acks, a1, s2, hcnt;
    bit ok;
    logic [3:0] t;
    stb = 0; cpl = 0; fs = -1; gap = -1; acks = 0; a1 = 0; s2 = 0; hcnt = 0; ok = 0;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_blocks = 4'(blocks);
    bus.req_multiple = (blocks != 1); bus.fifo_okay = 1'b1;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clock);
      if (cyc == 1) begin
        bus.req_valid = 1'b0;
        chk("req_ready_drop", int'(bus.req_ready), 0);
        chk("error_cleared", int'(bus.error), 0);
      end
      if (hcnt > 0) begin bus.fifo_okay = 1'b0; hcnt--; end
      else bus.fifo_okay = 1'b1;
      if (bus.transfer_complete) cpl++;
      if (!bus.busy) begin ok = 1; break; end
      if (bus.phys_strobe && !bus.phys_complete) begin
        stb++;
        if (stb == 1) fs = cyc;
        if (stb == 2) s2 = cyc;
        t = (tq.size() > 0) ? tq.pop_front() : 4'h2;
        bus.phys_complete = 1'b1; bus.phys_token = t[2:0]; bus.phys_timeout = t[3];
      end else if (bus.phys_ack && bus.phys_complete) begin
        bus.phys_complete = 1'b0;
        acks++;
        if (acks == 1) a1 = cyc;
        if (hold && acks == 1) hcnt = 10;
      end
    end
    if (!ok) chk("xfer_bound", 0, 1);
    if (s2 > 0) gap = s2 - a1;
  endtask

  typedef struct {
    bit wr; int blocks; int ntok; logic [31:0] toks; bit hold;
    int e_done, e_err, e_code, e_stb, e_cpl;
  } vec_t;

  initial begin
    vec_t vt[10];
    logic [3:0] rq[$];
    int stb, cpl, fs, gap, md, me, mc, ms, mp;
    bit wr, seen;
    int blocks, r;

    bus.req_valid = 0; bus.req_write = 0; bus.req_blocks = '0; bus.req_multiple = 0;
    bus.fifo_okay = 1; bus.phys_complete = 0; bus.phys_token = '0; bus.phys_timeout = 0;
`ifdef SEQ_ABORT_EN
    bus.abort = 0;
`endif
    // tokens: nibble i is {timeout, token} for strobe i
    vt[0] = '{1, 2, 2, 32'h22,    0, 2, 0, 0, 2, 1};
    vt[1] = '{1, 1, 3, 32'h255,   0, 1, 0, 0, 3, 1};
    vt[2] = '{1, 1, 3, 32'h555,   0, 0, 1, 1, 3, 0};
    vt[3] = '{0, 3, 3, 32'h000,   1, 3, 0, 0, 3, 1};
    vt[4] = '{1, 1, 1, 32'h8,     0, 0, 1, 3, 1, 0};
    vt[5] = '{1, 0, 1, 32'h2,     0, 1, 0, 0, 1, 1};
    vt[6] = '{1, 2, 2, 32'h62,    0, 1, 1, 2, 2, 0};
    vt[7] = '{0, 1, 1, 32'hD,     0, 0, 1, 3, 1, 0};
    vt[8] = '{1, 1, 2, 32'h25,    0, 1, 0, 0, 2, 1};
    vt[9] = '{1, 2, 5, 32'h25525, 0, 2, 0, 0, 5, 1};

    #12;
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_strobe", int'(bus.phys_strobe), 0);
    chk("rst_ack", int'(bus.phys_ack), 0);
    chk("rst_error", int'(bus.error), 0);
    chk("rst_blocks_done", int'(bus.blocks_done), 0);
    @(negedge clock) reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tq.delete();
      for (int k = 0; k < vt[i].ntok; k++) tq.push_back(vt[i].toks[4*k +: 4]);
      do_xfer(vt[i].wr, vt[i].blocks, vt[i].hold, stb, cpl, fs, gap);
      chk($sformatf("v%0d_blocks_done", i), int'(bus.blocks_done), vt[i].e_done);
      chk($sformatf("v%0d_error", i), int'(bus.error), vt[i].e_err);
      chk($sformatf("v%0d_code", i), int'(bus.error_code), vt[i].e_code);
      chk($sformatf("v%0d_strobes", i), stb, vt[i].e_stb);
      chk($sformatf("v%0d_complete", i), cpl, vt[i].e_cpl);
      chk($sformatf("v%0d_first_strobe", i), fs, 2);
      chk($sformatf("v%0d_phys_write", i), int'(bus.phys_write), int'(vt[i].wr));
      if (gap >= 0) chk($sformatf("v%0d_gap", i), gap, vt[i].hold ? 12 : 2);
    end

    // reset while a strobe is outstanding
    @(negedge clock);
    bus.req_valid = 1; bus.req_write = 1; bus.req_blocks = 4'd3;
    @(negedge clock) bus.req_valid = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      seen = bus.phys_strobe;
    end
    chk("mid_strobe_seen", int'(seen), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req_ready", int'(bus.req_ready), 1);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_strobe", int'(bus.phys_strobe), 0);
    chk("mid_rst_error", int'(bus.error), 0);
    chk("mid_rst_cpl", int'(bus.transfer_complete), 0);
    chk("mid_rst_blocks_done", int'(bus.blocks_done), 0);
    @(negedge clock) reset = 1'b1;

    for (int it = 0; it < 40; it++) begin
      wr = 1'($urandom_range(0, 1));
      blocks = $urandom_range(0, 15);
      rq.delete();
      for (int k = 0; k < 48; k++) begin
        r = $urandom_range(0, 19);
        if (r < 14)      rq.push_back(4'h2);
        else if (r < 18) rq.push_back(4'h5);
        else if (r < 19) rq.push_back(4'h6);
        else             rq.push_back({1'b1, 3'($urandom_range(0, 7))});
      end
      model(wr, blocks, rq, md, me, mc, ms, mp);
      tq = rq;
      do_xfer(wr, blocks, 0, stb, cpl, fs, gap);
      chk($sformatf("r%0d_blocks_done", it), int'(bus.blocks_done), md);
      chk($sformatf("r%0d_error", it), int'(bus.error), me);
      chk($sformatf("r%0d_code", it), int'(bus.error_code), mc);
      chk($sformatf("r%0d_strobes", it), stb, ms);
      chk($sformatf("r%0d_complete", it), cpl, mp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
